rv32_mtimer: RTL and testbench
==============================

// Module: rv32_mtimer
// PURPOSE
//  Memory-mapped RISC-V machine timer / software-interrupt responder on the core's data port.
//  Sits beside unified_memory port B and answers core loads/stores to its decoded window.
//  Port B timing is matched: byte write enables, read-first, READ_LATENCY-cycle read pipeline.
//  Drives MTIP/MSIP request lines to the core's Zicsr mip logic.
// PARAMETERS
//  READ_LATENCY  2   cycles from request to rdata_o; legal 1 or 2 (2 matches HIGH_PERFORMANCE RAM)
//  PRESCALE      1   clk_i cycles per mtime tick; legal 1..65535
// PORTS
//  clk_i         in   1   system clock, all logic on rising edge
//  rst_n_i       in   1   asynchronous active-low reset
//  sel_i         in   1   window decode from data address; request valid this cycle
//  addr_i        in   3   word offset inside window (data_address[4:2])
//  we_i          in   4   byte write enables, bit n -> wdata_i[8n+7:8n]
//  wdata_i       in   32  store data
//  rdata_o       out  32  load data, READ_LATENCY cycles after request; 0 when not selected
//  timer_irq_o   out  1   MTIP: registered (mtime >= mtimecmp)
//  soft_irq_o    out  1   MSIP: msip register bit 0
// BEHAVIOUR
//  Map: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 MSIP (bit0, rest read 0);
//   5..7 unmapped: read 0, writes ignored.
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescale cnt=0, read pipe=0,
//   rdata_o=0, timer_irq_o=0, soft_irq_o=0.
//  Prescaler: cnt counts 0..PRESCALE-1; tick when cnt==PRESCALE-1, then cnt->0.
//   PRESCALE=1 -> tick every cycle.
//  mtime: on tick, full 64-bit +1 (LO carry into HI); 64'hFFFF..FF wraps to 0.
//  Write (sel_i & |we_i): only enabled bytes of the addressed word change, next edge.
//   A write to MTIME_LO/HI beats the same-cycle tick for the whole 64-bit value:
//   written bytes take wdata, others keep old value, no increment that cycle.
//   Prescale cnt is unaffected by mtime writes.
//  Read: every cycle sel_i=1 captures the addressed word into stage 1; sel_i=0 captures 0.
//   Read-first: a same-cycle write returns the pre-write value.
//   READ_LATENCY=2: stage 1 -> stage 2 -> rdata_o; READ_LATENCY=1: stage 1 drives rdata_o.
//   Pipeline advances every cycle (no stall); back-to-back requests return in order.
//   rdata_o=0 for non-selected slots, so the top ORs it with RAM data under a registered mux.
//  timer_irq_o: registered each cycle from (mtime >= mtimecmp), unsigned 64-bit compare
//   of current register values; 1 cycle behind the registers; level, no latch.
//   Cleared only by raising mtimecmp or lowering mtime.
//  soft_irq_o = msip[0], updated on the edge of a write with we_i[0]=1.
//  Reset asserted mid-operation: all state returns to reset values immediately;
//   in-flight reads are dropped (rdata_o=0).
// TESTING
//  1 Reset, PRESCALE=1, idle 10 cycles -> read MTIME_LO returns 10 +/-1 (fixed offset),
//    rdata_o valid exactly 2 cycles after sel_i; timer_irq_o=0 throughout.
//  2 Write MTIME_LO=FFFF_FFFE, MTIME_HI=0, wait 3 ticks -> HI=1, LO=1 (carry across words).
//  3 Write MTIMECMP_HI=0, MTIMECMP_LO=20, mtime=0 -> timer_irq_o rises the cycle after mtime=20;
//    write MTIMECMP_LO=1000 -> timer_irq_o falls 1 cycle after the write lands.
//  4 Write MTIME_LO with we_i=4'b0010, wdata=32'h0000_AB00, on a tick cycle -> only byte1=AB,
//    other bytes unchanged, no increment that cycle.
//  5 Same-cycle write+read MSIP (wdata=1, we_i=4'b0001) -> rdata_o=0 (read-first);
//    soft_irq_o=1 next cycle; addr 6 read -> 0; sel_i=0 -> rdata_o=0.
//  6 PRESCALE=4: mtime +1 every 4 cycles; rst_n_i pulsed during a read ->
//    rdata_o=0, mtimecmp=all ones, timer_irq_o=0 asynchronously.

Source files
------------

// File: rtl/rv32_mtimer.sv
// RISC-V machine timer / software-interrupt block on the core data port.
// Matches RAM port B timing: byte enables, read-first, READ_LATENCY-deep read pipe.
module rv32_mtimer #(
  parameter int READ_LATENCY = 2,
  parameter int PRESCALE     = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sel_i,
  input  logic [2:0]  addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        timer_irq_o,
  output logic        soft_irq_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0]                 cnt;
  logic                          tick;
  logic [63:0]                   mtime;
  logic [63:0]                   mtimecmp;
  logic                          msip;
  logic [READ_LATENCY-1:0][31:0] rd_pipe;
  logic [31:0]                   cur_word;
  logic [31:0]                   wr_word;
  logic                          wr;

  assign tick       = (cnt == CW'(PRESCALE - 1));
  assign wr         = sel_i & (|we_i);
  assign rdata_o    = rd_pipe[READ_LATENCY-1];
  assign soft_irq_o = msip;

  // cur_word is the pre-write value, which is also what a same-cycle read returns.
  always_comb begin
    cur_word = '0;
    case (addr_i)
      3'd0:    cur_word = mtime[31:0];
      3'd1:    cur_word = mtime[63:32];
      3'd2:    cur_word = mtimecmp[31:0];
      3'd3:    cur_word = mtimecmp[63:32];
      3'd4:    cur_word = {31'b0, msip};
      default: cur_word = '0;
    endcase
    wr_word = cur_word;
    for (int b = 0; b < 4; b++)
      if (we_i[b]) wr_word[8*b +: 8] = wdata_i[8*b +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt         <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      timer_irq_o <= 1'b0;
      rd_pipe     <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);

      // A software write to either mtime half suppresses that cycle's increment.
      if (wr && addr_i == 3'd0)      mtime[31:0]  <= wr_word;
      else if (wr && addr_i == 3'd1) mtime[63:32] <= wr_word;
      else if (tick)                 mtime        <= mtime + 64'd1;

      if (wr && addr_i == 3'd2) mtimecmp[31:0]  <= wr_word;
      if (wr && addr_i == 3'd3) mtimecmp[63:32] <= wr_word;
      if (wr && addr_i == 3'd4 && we_i[0]) msip <= wdata_i[0];

      timer_irq_o <= (mtime >= mtimecmp);

      rd_pipe[0] <= sel_i ? cur_word : '0;
      for (int i = 1; i < READ_LATENCY; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_rv32_mtimer.sv
// Bench for rv32_mtimer: two instances (latency 2 / prescale 1, latency 1 / prescale 4)
// share one stimulus stream and are checked against a register-level model each cycle.
module tb_rv32_mtimer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [2:0]  addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        tirq_a, tirq_b, sirq_a, sirq_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_mtimer #(.READ_LATENCY(2), .PRESCALE(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .rdata_o(rdata_a), .timer_irq_o(tirq_a), .soft_irq_o(sirq_a));

  rv32_mtimer #(.READ_LATENCY(1), .PRESCALE(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .rdata_o(rdata_b), .timer_irq_o(tirq_b), .soft_irq_o(sirq_b));

  // Model state, index 0 = dut_a, 1 = dut_b
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  logic        m_irq  [2];
  int          m_cnt  [2];
  logic [31:0] m_h1   [2];
  logic [31:0] m_h2   [2];

  function automatic int ps(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] m_word(int k, logic [2:0] a);
    case (a)
      3'd0: return m_time[k][31:0];
      3'd1: return m_time[k][63:32];
      3'd2: return m_cmp[k][31:0];
      3'd3: return m_cmp[k][63:32];
      3'd4: return {31'b0, m_msip[k]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = 64'h0;
      m_cmp[k]  = {64{1'b1}};
      m_msip[k] = 1'b0;
      m_irq[k]  = 1'b0;
      m_cnt[k]  = 0;
      m_h1[k]   = 32'h0;
      m_h2[k]   = 32'h0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] rd, w;
    logic        tk, wt;
    for (int k = 0; k < 2; k++) begin
      rd = sel ? m_word(k, addr) : 32'h0;
      m_irq[k] = (m_time[k] >= m_cmp[k]);
      m_h2[k] = m_h1[k];
      m_h1[k] = rd;
      tk = (m_cnt[k] == ps(k) - 1);
      m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
      wt = 1'b0;
      if (sel && we != 4'b0) begin
        w = m_word(k, addr);
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wdata[8*b +: 8];
        case (addr)
          3'd0: begin m_time[k][31:0]  = w; wt = 1'b1; end
          3'd1: begin m_time[k][63:32] = w; wt = 1'b1; end
          3'd2: m_cmp[k][31:0]  = w;
          3'd3: m_cmp[k][63:32] = w;
          3'd4: if (we[0]) m_msip[k] = wdata[0];
          default: ;
        endcase
      end
      if (!wt && tk) m_time[k] = m_time[k] + 64'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_cmp();
    chk("a_rdata", {32'h0, rdata_a}, {32'h0, m_h2[0]});
    chk("b_rdata", {32'h0, rdata_b}, {32'h0, m_h1[1]});
    chk("a_tirq", {63'h0, tirq_a}, {63'h0, m_irq[0]});
    chk("b_tirq", {63'h0, tirq_b}, {63'h0, m_irq[1]});
    chk("a_sirq", {63'h0, sirq_a}, {63'h0, m_msip[0]});
    chk("b_sirq", {63'h0, sirq_b}, {63'h0, m_msip[1]});
  endtask

  // One clock cycle: drive request, let the edge happen, advance model, compare.
  task automatic cyc(input logic s, input logic [2:0] a, input logic [3:0] w, input logic [31:0] d);
    sel = s; addr = a; we = w; wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 4'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    model_cmp();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] v0;
    int          n;
    logic        seen;
    rst_n = 1'b0; sel = 1'b0; addr = '0; we = '0; wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    model_cmp();
    chk("rst_rdata_a", {32'h0, rdata_a}, 64'h0);
    chk("rst_tirq_a", {63'h0, tirq_a}, 64'h0);
    rst_n = 1'b1;

    // 1: free-running count and read latency
    idle(10);
    cyc(1'b1, 3'd0, 4'h0, 32'h0);
    chk("t1_b_lat1", {32'h0, rdata_b}, 64'd2);
    chk("t1_a_not_yet", {32'h0, rdata_a}, 64'd0);
    idle(1);
    chk("t1_a_mtime_lo", {32'h0, rdata_a}, 64'd10);
    chk("t1_a_tirq", {63'h0, tirq_a}, 64'h0);

    // 2: carry from LO into HI
    cyc(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFE);
    cyc(1'b1, 3'd1, 4'hF, 32'h0);
    idle(3);
    cyc(1'b1, 3'd0, 4'h0, 32'h0);
    cyc(1'b1, 3'd1, 4'h0, 32'h0);
    chk("t2_lo", {32'h0, rdata_a}, 64'd1);
    idle(1);
    chk("t2_hi", {32'h0, rdata_a}, 64'd1);

    // 3: compare interrupt rise and fall
    cyc(1'b1, 3'd0, 4'hF, 32'h0);
    cyc(1'b1, 3'd1, 4'hF, 32'h0);
    cyc(1'b1, 3'd3, 4'hF, 32'h0);
    cyc(1'b1, 3'd2, 4'hF, 32'd20);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      idle(1);
      n++;
      if (tirq_a) seen = 1'b1;
    end
    chk("t3_rise_cycle", 64'(n), 64'd19);
    cyc(1'b1, 3'd2, 4'hF, 32'd1000);
    chk("t3_still_high", {63'h0, tirq_a}, 64'h1);
    idle(1);
    chk("t3_fall", {63'h0, tirq_a}, 64'h0);

    // 4: single-byte write on a tick cycle
    cyc(1'b1, 3'd0, 4'hF, 32'h1234_5678);
    cyc(1'b1, 3'd1, 4'hF, 32'h0);
    cyc(1'b1, 3'd0, 4'b0010, 32'h0000_AB00);
    cyc(1'b1, 3'd0, 4'h0, 32'h0);
    chk("t4_b_byte", {32'h0, rdata_b}, 64'h1234_AB78);
    idle(1);
    chk("t4_a_byte", {32'h0, rdata_a}, 64'h1234_AB78);

    // 5: MSIP read-first, unmapped read, deselected slot
    cyc(1'b1, 3'd4, 4'b0001, 32'h1);
    chk("t5_b_readfirst", {32'h0, rdata_b}, 64'h0);
    chk("t5_sirq_a", {63'h0, sirq_a}, 64'h1);
    cyc(1'b1, 3'd6, 4'h0, 32'hDEAD_BEEF);
    chk("t5_a_readfirst", {32'h0, rdata_a}, 64'h0);
    cyc(1'b1, 3'd4, 4'h0, 32'h0);
    chk("t5_b_msip", {32'h0, rdata_b}, 64'h1);
    chk("t5_a_unmapped", {32'h0, rdata_a}, 64'h0);
    idle(1);
    chk("t5_a_msip", {32'h0, rdata_a}, 64'h1);
    chk("t5_b_desel", {32'h0, rdata_b}, 64'h0);

    // 6: prescale 4 rate, then reset during an in-flight read
    cyc(1'b1, 3'd0, 4'h0, 32'h0);
    v0 = rdata_b;
    idle(7);
    cyc(1'b1, 3'd0, 4'h0, 32'h0);
    chk("t6_b_rate", {32'h0, rdata_b - v0}, 64'd2);
    cyc(1'b1, 3'd3, 4'hF, 32'h0);
    cyc(1'b1, 3'd2, 4'hF, 32'h0);
    idle(1);
    chk("t6_a_tirq_pre", {63'h0, tirq_a}, 64'h1);
    cyc(1'b1, 3'd2, 4'h0, 32'h0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_rdata_a", {32'h0, rdata_a}, 64'h0);
    chk("t6_rst_rdata_b", {32'h0, rdata_b}, 64'h0);
    chk("t6_rst_tirq_a", {63'h0, tirq_a}, 64'h0);
    chk("t6_rst_sirq_a", {63'h0, sirq_a}, 64'h0);
    rst_n = 1'b1;
    #1;
    cyc(1'b1, 3'd3, 4'h0, 32'h0);
    chk("t6_b_cmp_hi", {32'h0, rdata_b}, 64'hFFFF_FFFF);
    idle(1);
    chk("t6_a_cmp_hi", {32'h0, rdata_a}, 64'hFFFF_FFFF);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        s;
      logic [2:0]  a;
      logic [3:0]  w;
      logic [31:0] d;
      s = ($urandom_range(0, 9) < 7);
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      cyc(s, a, w, d);
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
